// File: rtl/ssd1306_pkg.sv
// Shared constants, frame-state encoding and command ROM for the SSD1306-style
// framebuffer link transmitter.
package ssd1306_pkg;

  // Resync prefix: page 0, column high nibble 0, column low nibble 0.
  localparam logic [7:0] CMD_PAGE0  = 8'hB0;
  localparam logic [7:0] CMD_COLHI0 = 8'h10;
  localparam logic [7:0] CMD_COLLO0 = 8'h00;
  localparam int         N_CMD      = 3;

  // Default framebuffer geometry.
  localparam int FB_PAGES = 8;
  localparam int FB_COLS  = 128;
  localparam int FB_BYTES = FB_PAGES * FB_COLS;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DONE  = 3'd4
  } frame_state_e;

  // Command byte for prefix position idx (0..N_CMD-1).
  function automatic logic [7:0] cmd_byte(input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = CMD_PAGE0;
      2'd1:    b = CMD_COLHI0;
      default: b = CMD_COLLO0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/ssd1306_spi_shift.sv
// Clock divider, wclk generator and MSB-first byte shifter. A byte is loaded at
// begin_i, then each further byte is requested with byte_req_o on the falling
// wclk edge after bit0; load_i is sampled in that same cycle. Without a load
// the shifter stops with wclk low and din low.
module ssd1306_spi_shift
  import ssd1306_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       begin_i,
  input  logic [7:0] begin_byte_i,
  input  logic       load_i,
  input  logic [7:0] load_byte_i,
  output logic       byte_req_o,
  output logic       wclk_o,
  output logic       din_o
);

  localparam int            DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] HALF_END = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic          wclk_q, wclk_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic          active_q, active_d;
  logic          half_end_s;

  assign half_end_s = (div_cnt_q == HALF_END);
  assign byte_req_o = active_q & half_end_s & wclk_q & (bit_idx_q == 3'd7);
  assign wclk_o     = wclk_q;
  assign din_o      = shreg_q[7];

  // Half-period counting, wclk toggling and shifting on each falling edge.
  always_comb begin
    div_cnt_d = div_cnt_q;
    wclk_d    = wclk_q;
    shreg_d   = shreg_q;
    bit_idx_d = bit_idx_q;
    active_d  = active_q;
    if (begin_i) begin
      div_cnt_d = '0;
      wclk_d    = 1'b0;
      shreg_d   = begin_byte_i;
      bit_idx_d = 3'd0;
      active_d  = 1'b1;
    end else if (active_q) begin
      if (half_end_s) begin
        div_cnt_d = '0;
        wclk_d    = ~wclk_q;
        if (wclk_q) begin
          if (bit_idx_q == 3'd7) begin
            bit_idx_d = 3'd0;
            if (load_i) begin
              shreg_d = load_byte_i;
            end else begin
              shreg_d  = 8'h00;
              active_d = 1'b0;
            end
          end else begin
            shreg_d   = {shreg_q[6:0], 1'b0};
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          shreg_d = shreg_q;
        end
      end else begin
        div_cnt_d = div_cnt_q + DW'(1);
      end
    end else begin
      active_d = 1'b0;
    end
  end

  // Shifter state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
      wclk_q    <= 1'b0;
      shreg_q   <= 8'h00;
      bit_idx_q <= 3'd0;
      active_q  <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      wclk_q    <= wclk_d;
      shreg_q   <= shreg_d;
      bit_idx_q <= bit_idx_d;
      active_q  <= active_d;
    end
  end

endmodule

// File: rtl/ssd1306_spi_tx.sv
// Frame transmitter: on start, sends the page-0 resync prefix (dc=0) followed
// by the whole framebuffer (dc=1) as one continuous MSB-first bit stream.
module ssd1306_spi_tx
  import ssd1306_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int PAGES   = FB_PAGES,
  parameter int COLS    = FB_COLS,
  parameter int FB_AW   = 10
) (
  input  logic             CLK25MHz,
  input  logic             reset_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [FB_AW-1:0] fb_raddr,
  input  logic [7:0]       fb_rdata,
  output logic             wclk,
  output logic [1:0]       din,
  output logic             cs,
  output logic             dc
);

  localparam int             TOTAL     = N_CMD + PAGES * COLS;
  localparam int             BCW       = FB_AW + 1;
  localparam int             DW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(TOTAL - 1);
  localparam logic [BCW-1:0] NCMD_B    = BCW'(N_CMD);
  localparam logic [BCW-1:0] NCMD_M1   = BCW'(N_CMD - 1);
  localparam logic [DW-1:0]  HOLD_END  = DW'(CLK_DIV - 1);

  frame_state_e     state_q, state_d;
  logic [BCW-1:0]   byte_cnt_q, byte_cnt_d;
  logic [DW-1:0]    hold_cnt_q, hold_cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             cs_q, cs_d;
  logic             dc_q, dc_d;
  logic [FB_AW-1:0] fb_raddr_q, fb_raddr_d;
  logic [BCW-1:0]   nxt_s;
  logic             begin_s, load_s, byte_req_s, wclk_s, din_s;
  logic [7:0]       load_byte_s;

  ssd1306_spi_shift #(.CLK_DIV(CLK_DIV)) u_shift (
    .clk          (CLK25MHz),
    .rst_n        (reset_n),
    .begin_i      (begin_s),
    .begin_byte_i (CMD_PAGE0),
    .load_i       (load_s),
    .load_byte_i  (load_byte_s),
    .byte_req_o   (byte_req_s),
    .wclk_o       (wclk_s),
    .din_o        (din_s)
  );

  assign busy     = busy_q;
  assign done     = done_q;
  assign cs       = cs_q;
  assign dc       = dc_q;
  assign fb_raddr = fb_raddr_q;
  assign wclk     = wclk_s;
  assign din      = {1'b0, din_s};

  // Frame FSM: next byte selection, framebuffer prefetch and framing outputs.
  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    cs_d        = cs_q;
    dc_d        = dc_q;
    fb_raddr_d  = fb_raddr_q;
    begin_s     = 1'b0;
    load_s      = 1'b0;
    load_byte_s = 8'h00;
    nxt_s       = byte_cnt_q + BCW'(1);
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_SETUP;
          busy_d     = 1'b1;
          cs_d       = 1'b0;
          dc_d       = 1'b0;
          byte_cnt_d = '0;
          begin_s    = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (wclk_s) begin
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_SETUP;
        end
      end
      ST_SHIFT: begin
        if (byte_req_s) begin
          if (byte_cnt_q == LAST_BYTE) begin
            state_d    = ST_HOLD;
            hold_cnt_d = '0;
          end else begin
            load_s     = 1'b1;
            byte_cnt_d = nxt_s;
            dc_d       = (nxt_s >= NCMD_B);
            if (nxt_s < NCMD_B) begin
              load_byte_s = cmd_byte(nxt_s[1:0]);
            end else begin
              load_byte_s = fb_rdata;
            end
            // Prefetch the byte after the one now entering the shifter.
            if ((nxt_s >= NCMD_M1) && (nxt_s < LAST_BYTE)) begin
              fb_raddr_d = FB_AW'(nxt_s - NCMD_M1);
            end else begin
              fb_raddr_d = fb_raddr_q;
            end
          end
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_HOLD: begin
        if (hold_cnt_q == HOLD_END) begin
          state_d = ST_DONE;
          cs_d    = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          hold_cnt_d = hold_cnt_q + DW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        cs_d    = 1'b1;
      end
    endcase
  end

  // Frame state and registered framing outputs.
  always_ff @(posedge CLK25MHz or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      byte_cnt_q <= '0;
      hold_cnt_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cs_q       <= 1'b1;
      dc_q       <= 1'b0;
      fb_raddr_q <= '0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      cs_q       <= cs_d;
      dc_q       <= dc_d;
      fb_raddr_q <= fb_raddr_d;
    end
  end

endmodule

// File: tb/tb_ssd1306_spi_tx.sv
// Self-checking bench for ssd1306_spi_tx: three instances (CLK_DIV 2 full size,
// CLK_DIV 1 and 5 reduced size) against a bit-stream and receiver model.
`timescale 1ns/1ps
module tb_ssd1306_spi_tx;

  logic clk = 1'b0;
  always #20 clk = ~clk;

  logic       reset_n;
  logic       start0, start1, start2;
  logic       busy0, done0, wclk0, cs0, dc0;
  logic       busy1, done1, wclk1, cs1, dc1;
  logic       busy2, done2, wclk2, cs2, dc2;
  logic [1:0] din0, din1, din2;
  logic [9:0] raddr0;
  logic [3:0] raddr1, raddr2;
  logic [7:0] rdata0, rdata1, rdata2;

  logic [7:0] fb_main [1024];
  logic [7:0] fb_small [16];

  int          n_cmp, n_bad;
  logic [11:0] rx_sh;
  int          rx_addr;
  logic        rx_mem [8192];

  ssd1306_spi_tx #(.CLK_DIV(2), .PAGES(8), .COLS(128), .FB_AW(10)) dut0 (
    .CLK25MHz(clk), .reset_n(reset_n), .start(start0), .busy(busy0), .done(done0),
    .fb_raddr(raddr0), .fb_rdata(rdata0), .wclk(wclk0), .din(din0), .cs(cs0), .dc(dc0));
  ssd1306_spi_tx #(.CLK_DIV(1), .PAGES(1), .COLS(16), .FB_AW(4)) dut1 (
    .CLK25MHz(clk), .reset_n(reset_n), .start(start1), .busy(busy1), .done(done1),
    .fb_raddr(raddr1), .fb_rdata(rdata1), .wclk(wclk1), .din(din1), .cs(cs1), .dc(dc1));
  ssd1306_spi_tx #(.CLK_DIV(5), .PAGES(1), .COLS(16), .FB_AW(4)) dut2 (
    .CLK25MHz(clk), .reset_n(reset_n), .start(start2), .busy(busy2), .done(done2),
    .fb_raddr(raddr2), .fb_rdata(rdata2), .wclk(wclk2), .din(din2), .cs(cs2), .dc(dc2));

  // Synchronous framebuffer RAMs: data valid one cycle after the address.
  always @(posedge clk) begin
    rdata0 <= fb_main[raddr0];
    rdata1 <= fb_small[raddr1];
    rdata2 <= fb_small[raddr2];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    n_cmp++;
    assert (obs === req) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, req);
    end
  endtask

  task automatic sample(input int inst, output logic w, output logic [1:0] d, output logic c,
                        output logic dcv, output logic b, output logic dn, output int ra);
    case (inst)
      0: begin w = wclk0; d = din0; c = cs0; dcv = dc0; b = busy0; dn = done0; ra = int'(raddr0); end
      1: begin w = wclk1; d = din1; c = cs1; dcv = dc1; b = busy1; dn = done1; ra = int'(raddr1); end
      default: begin w = wclk2; d = din2; c = cs2; dcv = dc2; b = busy2; dn = done2; ra = int'(raddr2); end
    endcase
  endtask

  task automatic set_start(input int inst, input logic v);
    case (inst)
      0: start0 = v;
      1: start1 = v;
      default: start2 = v;
    endcase
  endtask

  task automatic check_idle(input int inst, input string tag);
    logic w, c, dcv, b, dn; logic [1:0] d; int ra;
    sample(inst, w, d, c, dcv, b, dn, ra);
    chk({tag, "_cs"}, c, 1);
    chk({tag, "_wclk"}, w, 0);
    chk({tag, "_din"}, d, 0);
    chk({tag, "_dc"}, dcv, 0);
    chk({tag, "_busy"}, b, 0);
    chk({tag, "_done"}, dn, 0);
    chk({tag, "_raddr"}, ra, 0);
  endtask

  // Receiver: command bits shift a 12-bit window (0xB01 resets the write
  // address); data bits are written to consecutive bit addresses.
  task automatic rx_bit(input logic bitv, input logic dcv);
    if (dcv === 1'b0) begin
      rx_sh = {rx_sh[10:0], bitv};
      if (rx_sh == 12'hB01) rx_addr = 0;
    end else begin
      rx_mem[rx_addr % 8192] = bitv;
      rx_addr++;
    end
  endtask

  // One frame from the current negedge; abort_bit >= 0 applies reset after that
  // many rising edges; poke pulses start mid-frame and on the done cycle.
  task automatic run_frame(input int inst, input int cdiv, input int nbytes,
                           input int abort_bit, input bit poke);
    logic [7:0] bytes_q [$];
    int nbits, done_exp, limit, cyc, rises, last_chg, done_cnt, done_cyc;
    int busy_err, cs_err, din1_err, cs_low, ra;
    logic w, c, dcv, b, dn, pw;
    logic [1:0] d, prev_sig;
    bit finished;
    bytes_q = {8'hB0, 8'h10, 8'h00};
    for (int i = 0; i < nbytes; i++) bytes_q.push_back(inst == 0 ? fb_main[i] : fb_small[i]);
    nbits    = 8 * bytes_q.size();
    done_exp = 1 + (2 * nbits + 1) * cdiv;
    limit    = done_exp + 2 * cdiv + 8;
    sample(inst, w, d, c, dcv, b, dn, ra);
    prev_sig = {d[0], dcv};
    set_start(inst, 1'b1);
    @(negedge clk);
    cyc = 1; rises = 0; last_chg = 0; done_cnt = 0; done_cyc = -1;
    busy_err = 0; cs_err = 0; din1_err = 0; cs_low = 0; pw = 1'b0; finished = 1'b0;
    sample(inst, w, d, c, dcv, b, dn, ra);
    chk("first_cs", c, 0);
    chk("first_busy", b, 1);
    chk("first_dc", dcv, 0);
    chk("first_din", d[0], 1);
    chk("first_wclk", w, 0);
    while (!finished) begin
      set_start(inst, 1'b0);
      sample(inst, w, d, c, dcv, b, dn, ra);
      if ({d[0], dcv} !== prev_sig) last_chg = cyc;
      prev_sig = {d[0], dcv};
      if (d[1] !== 1'b0) din1_err++;
      if (b !== (cyc < done_exp)) busy_err++;
      if (c !== (cyc >= done_exp)) cs_err++;
      if (c === 1'b0) cs_low++;
      if (w === 1'b1 && pw === 1'b0) begin
        chk("rise_time", cyc, 1 + cdiv * (2 * rises + 1));
        chk("rise_setup", (cyc - last_chg) >= cdiv, 1);
        chk("din_bit", d[0], bytes_q[rises / 8][7 - rises % 8]);
        chk("dc_bit", dcv, (rises / 8) >= 3);
        if (inst == 0) rx_bit(d[0], dcv);
        rises++;
        if (rises == abort_bit) begin
          reset_n = 1'b0;
          #1;
          check_idle(inst, "abort");
          @(negedge clk);
          reset_n = 1'b1;
          return;
        end
        if (poke && rises == nbits / 2) set_start(inst, 1'b1);
      end else if (w === 1'b0 && pw === 1'b1) begin
        chk("fall_time", cyc, 1 + 2 * cdiv * rises);
      end
      pw = w;
      if (dn === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
        if (poke) set_start(inst, 1'b1);
      end
      if (cyc >= limit) finished = 1'b1;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    chk("bit_count", rises, nbits);
    chk("done_pulses", done_cnt, 1);
    chk("done_cycle", done_cyc, done_exp);
    chk("cs_low_len", cs_low, (2 * nbits + 1) * cdiv);
    chk("busy_errs", busy_err, 0);
    chk("cs_errs", cs_err, 0);
    chk("din1_errs", din1_err, 0);
    chk("raddr_hold", ra, nbytes - 1);
    chk("end_wclk", w, 0);
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; rx_sh = 12'h000; rx_addr = 0;
    reset_n = 1'b0; start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    for (int i = 0; i < 1024; i++) fb_main[i] = 8'($urandom);
    for (int i = 0; i < 16; i++) fb_small[i] = 8'($urandom);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) check_idle(i, "rst_hold");
    reset_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) check_idle(i, "rst_rel");

    // Frame abandoned by reset at bit 5000, then a full frame with stray starts.
    run_frame(0, 2, 1024, 5000, 1'b0);
    repeat (2) @(negedge clk);
    check_idle(0, "post_abort");
    for (int i = 0; i < 1024; i++) fb_main[i] = 8'($urandom);
    fb_main[0] = 8'hB0; fb_main[1] = 8'h01; fb_main[1023] = 8'hFF;
    run_frame(0, 2, 1024, -1, 1'b1);
    chk("rx_addr_end", rx_addr, 8192);
    for (int n = 0; n < 1024; n++) begin
      for (int r = 0; r < 8; r++) begin
        chk("rx_image", rx_mem[(n / 128) * 1024 + (n % 128) * 8 + 7 - r], fb_main[n][r]);
      end
    end

    // Reduced geometry at the fastest and a slow divider.
    run_frame(1, 1, 16, -1, 1'b1);
    for (int i = 0; i < 16; i++) fb_small[i] = 8'($urandom);
    run_frame(2, 5, 16, -1, 1'b1);
    run_frame(2, 5, 16, -1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
